// File: rtl/self_test_rx_pkg.sv
// self_test shared package: FSM states, frame constants, parity helper.
// Imported by both the self_test receiver and transmitter.
package self_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_DATA_BITS = 32;
  localparam logic [3:0] SYNC_HDR_DEFAULT = 4'hA;

  // Parity bit that makes data plus parity carry an even count of ones.
  function automatic logic even_parity(
    input logic [FRAME_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/self_test_rx_if.sv
// self_test receiver bus: serial line in, received word and status out.
// master = receiver side, slave = line driver / status consumer.
interface self_test_rx_if;
  import self_test_pkg::*;

  logic                       rx_in;
  logic [FRAME_DATA_BITS-1:0] data_out;
  logic                       rx_done;
  logic                       rx_valid;
  logic                       parity_err;
  logic                       frame_err;
  logic                       sync_err;
  logic                       busy;

  modport master (
    input  rx_in,
    output data_out,
    output rx_done,
    output rx_valid,
    output parity_err,
    output frame_err,
    output sync_err,
    output busy
  );

  modport slave (
    output rx_in,
    input  data_out,
    input  rx_done,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  sync_err,
    input  busy
  );

endinterface

// File: rtl/self_test_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports: clk, rst_n, d (async in), q (synced out); resets to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/self_test_rx.sv
// self_test serial receiver: start, 32 data MSB-first, even parity, stop.
// Ports: clk, rst_n, bus (self_test_rx_if.master: rx_in in, word/status out).
module self_test_rx
  import self_test_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [3:0] SYNC_HDR     = SYNC_HDR_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  self_test_rx_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [5:0] LAST_BIT = 6'(FRAME_DATA_BITS - 1);

  state_t                     state;
  logic                       rx_s;
  logic                       rx_prev;
  logic [TW-1:0]              timer;
  logic [5:0]                 bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shift;
  logic                       par_bit;

  logic [FRAME_DATA_BITS-1:0] data_q;
  logic                       done_q;
  logic                       valid_q;
  logic                       pe_q;
  logic                       fe_q;
  logic                       se_q;
  logic                       busy_q;

  logic pe_n;
  logic fe_n;
  logic se_n;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.rx_in),
    .q    (rx_s)
  );

  // Error terms evaluated on the stop-bit sample cycle.
  assign pe_n = even_parity(shift) ^ par_bit;
  assign fe_n = ~rx_s;
  assign se_n = shift[FRAME_DATA_BITS-1 -: 4] != SYNC_HDR;

  // rx_prev tracks the line every cycle, so after a low stop bit the
  // line must be seen high again before a new falling edge can arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rx_prev <= 1'b1;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state  <= START;
            timer  <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer <= '0;
            shift <= {shift[FRAME_DATA_BITS-2:0], rx_s};
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PARITY: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            state   <= IDLE;
            busy_q  <= 1'b0;
            data_q  <= shift;
            done_q  <= 1'b1;
            pe_q    <= pe_n;
            fe_q    <= fe_n;
            se_q    <= se_n;
            valid_q <= ~(pe_n | fe_n | se_n);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.rx_done    = done_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.sync_err   = se_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_self_test_rx.sv
// Scoreboard bench for self_test_rx at CLKS_PER_BIT=4.
// Stimulus pushes expected frames; a negedge monitor pops on rx_done.
module tb_self_test_rx;

  localparam int CPB = 4;

  typedef struct {
    logic [31:0] data;
    logic        pe;
    logic        fe;
    logic        se;
    logic        vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  self_test_rx_if bus();

  self_test_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_HDR    (4'hA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t q[$];
  int   vt[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t e_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: one pop per rx_done; any extra pulse finds an empty queue.
  always @(negedge clk) begin
    if (bus.rx_valid) vt.push_back(cyc);
    if (bus.rx_valid && !bus.rx_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL valid_wo_done: rx_valid=1 rx_done=0 at cyc %0d", cyc);
    end
    if (bus.rx_done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: data %h at cyc %0d",
                 bus.data_out, cyc);
      end else begin
        e_m = q.pop_front();
        chk("data_out", bus.data_out, e_m.data);
        chk("parity_err", 32'(bus.parity_err), 32'(e_m.pe));
        chk("frame_err", 32'(bus.frame_err), 32'(e_m.fe));
        chk("sync_err", 32'(bus.sync_err), 32'(e_m.se));
        chk("rx_valid", 32'(bus.rx_valid), 32'(e_m.vld));
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic par,
                            input logic stp, input logic xpe,
                            input logic xfe, input logic xse);
    exp_t e;
    e.data = d;
    e.pe   = xpe;
    e.fe   = xfe;
    e.se   = xse;
    e.vld  = ~(xpe | xfe | xse);
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 31; i >= 0; i--) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run time limit %0d reached", 1000000);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    int t;
    logic [31:0] w;

    bus.rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_rx_done", 32'(bus.rx_done), 32'h0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_sync_err", 32'(bus.sync_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    idle(3);

    send_frame(32'hA201BEAF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    k = vt.size();
    send_frame(32'hA612BEAF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(32'hA623BEAF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    if (vt.size() >= k + 2) begin
      chk("b2b_gap", 32'(vt[k+1] - vt[k]), 32'd140);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_pulses: got %0d want %0d", vt.size() - k, 2);
    end

    send_frame(32'hA623BEAF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    chk("pe_hold", 32'(bus.parity_err), 32'h1);

    send_frame(32'h5201BEAF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    send_frame(32'hA201BEAF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("fe_hold", 32'(bus.frame_err), 32'h1);

    d0 = done_cnt;
    bus.rx_in = 1'b0;
    @(negedge clk);
    bus.rx_in = 1'b1;
    for (t = 0; t < 8 && !bus.busy; t++) @(negedge clk);
    chk("glitch_busy_rise", 32'(bus.busy), 32'h1);
    for (t = 0; t < 8 && bus.busy; t++) @(negedge clk);
    chk("glitch_busy_fall_le4", 32'(t <= 4), 32'h1);
    idle(3);
    chk("glitch_no_done", 32'(done_cnt), 32'(d0));

    d0 = done_cnt;
    w = 32'hA201BEAF;
    send_bit(1'b0);
    for (int i = 31; i > 21; i--) send_bit(w[i]);
    chk("busy_midframe", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    bus.rx_in = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_data_out", bus.data_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    send_frame(32'hA201BEAF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("after_rst_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/self_test_rx.md
SELF_TEST_RX -- requirements
Module: self_test_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, giving clocks per serial bit; legal values are even and at least 4.
REQ-002 The block SHALL have parameter SYNC_HDR, default 4'hA, giving the required value of received word bits [31:28].
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_in  input  1  serial line driven by the self_test tx_out of the adjacent layer; idles high.
REQ-006 data_out  output  32  last received word.
REQ-007 rx_done  output  1  one-cycle pulse marking the end of each frame.
REQ-008 rx_valid  output  1  one-cycle pulse, equal to rx_done AND no error flag set.
REQ-009 parity_err  output  1  parity error of the last frame.
REQ-010 frame_err  output  1  stop-bit error of the last frame.
REQ-011 sync_err  output  1  header mismatch of the last frame.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The frame SHALL be: start bit 0; 32 data bits, MSB first; one even-parity bit (total ones across data and parity is even); stop bit 1.
REQ-014 rx_in SHALL pass through a 2-FF synchronizer before any use; all latency figures below are counted from the synchronized signal.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START: on a synchronized 1->0 transition; the bit-timer is cleared.
REQ-017 START: the line SHALL be re-sampled after CLKS_PER_BIT/2 clocks; if 0, go to DATA with the timer cleared; if 1 (glitch), return to IDLE with no flag and no pulse.
REQ-018 DATA: one bit SHALL be sampled every CLKS_PER_BIT clocks (mid-bit) and shifted in MSB-first; a 6-bit counter tracks the bits; after bit 32, go to PARITY.
REQ-019 PARITY: sample once at mid-bit, then go to STOP.
REQ-020 STOP: sample at mid-bit, then return to IDLE in the next cycle.
REQ-021 Timing of the STOP sample cycle: in the next clock, data_out SHALL load the shift register, rx_done SHALL pulse, all three error flags SHALL update, and busy SHALL fall.
REQ-022 Error flags SHALL hold until the next rx_done.
REQ-023 data_out SHALL load even when errors are present.
REQ-024 frame_err=1 when the stop sample is 0; in that case the FSM SHALL still return to IDLE and SHALL wait for the line to be high for at least one sample before it re-arms falling-edge detection.
REQ-025 sync_err=1 when the received bits [31:28] != SYNC_HDR.
REQ-026 parity_err=1 when the ones count over 33 bits is odd.
REQ-027 A falling edge on rx_in during any non-IDLE state SHALL be ignored; there is no resynchronization mid-frame.
REQ-028 Back-to-back frames (a start bit immediately after a stop bit) SHALL be received with no lost bits.

Reset
REQ-029 While rst_n=0: FSM in IDLE; synchronizer flops = 1; data_out = 0; rx_done, rx_valid, all error flags and busy = 0; timer, bit counter and shift register = 0.
REQ-030 An assertion of rst_n mid-frame SHALL abort the frame with no rx_done; after release, the block SHALL wait for a new falling edge.

Structure
REQ-031 Package self_test_pkg SHALL hold the state enum, FRAME_DATA_BITS=32, SYNC_HDR_DEFAULT=4'hA, and an even-parity function shared with the transmitter.
REQ-032 The synchronizer SHALL be the only sub-module, named sync_2ff; the FSM, timer and shifter SHALL be inline.

Verification (CLKS_PER_BIT=4, one frame = 140 clocks)
REQ-033 Clean frame 32'hA201BEAF with parity 0 -> data_out=A201BEAF, rx_done=rx_valid=1 for exactly one cycle, all error flags 0.
REQ-034 Frames A612BEAF (parity 0) and A623BEAF (parity 1), sent back-to-back -> two rx_valid pulses exactly 140 clocks apart, with the correct data on each.
REQ-035 Frame A623BEAF sent with parity 0 -> parity_err=1, rx_valid=0, data_out=A623BEAF.
REQ-036 Frame 32'h5201BEAF with correct parity -> sync_err=1, rx_valid=0; stop bit forced to 0 -> frame_err=1.
REQ-037 A 1-clock low glitch on an idle line -> no rx_done, busy returns to 0 within 4 clocks.
REQ-038 rst_n pulsed low at data bit 10, then a clean A201BEAF sent -> only one rx_done, with data_out=A201BEAF.
